// File: rtl/alu_flag_if.sv
// Signal bundle between the ALU status stage / control unit and the Z80 F register.
interface alu_flag_if #(
    parameter int alu_width = 8
);
    logic                 c;
    logic                 n;
    logic                 pv;
    logic                 h;
    logic                 s;
    logic                 z;
    logic [alu_width-1:0] op_result;
    logic                 upd_valid;
    logic [7:0]           upd_mask;
    logic                 load_valid;
    logic [7:0]           load_data;
    logic                 ex_af;
    logic [2:0]           cc_sel;
    logic [7:0]           f;
    logic [7:0]           f_shadow;
    logic                 cc_true;
    logic                 f_changed;

    modport master (
        output c, n, pv, h, s, z, op_result, upd_valid, upd_mask,
               load_valid, load_data, ex_af, cc_sel,
        input  f, f_shadow, cc_true, f_changed
    );

    modport slave (
        input  c, n, pv, h, s, z, op_result, upd_valid, upd_mask,
               load_valid, load_data, ex_af, cc_sel,
        output f, f_shadow, cc_true, f_changed
    );
endinterface

// File: rtl/alu_flag_register.sv
// Z80 F/F' register pair with masked ALU capture, POP AF load, EX AF,AF' swap and cc decode.
// Define ALU_FLAG_XY_EN to make the undocumented X bits (5 and 3) writable.
module alu_flag_register #(
    parameter int alu_width = 8  // only 8 is meaningful; F layout is fixed
) (
    input  logic       clk,
    input  logic       reset,
    alu_flag_if.slave  bus
);
`ifdef ALU_FLAG_XY_EN
    localparam logic [7:0] keep_mask   = 8'hFF;
    localparam logic [7:0] reset_value = 8'hFF;
`else
    localparam logic [7:0] keep_mask   = 8'hD7;
    localparam logic [7:0] reset_value = 8'hD7;
`endif

    logic [7:0] bank0_reg;
    logic [7:0] bank1_reg;
    logic       bank_sel_reg;
    logic       f_changed_reg;

    logic [7:0] active;
    logic [7:0] inactive;
    logic [7:0] alu_flags;
    logic [7:0] upd_value;
    logic [7:0] write_value;
    logic [7:0] f_next;
    logic       write_en;
    logic       cc_bit;
    logic       unused_op_bits;

    assign active    = bank_sel_reg ? bank1_reg : bank0_reg;
    assign inactive  = bank_sel_reg ? bank0_reg : bank1_reg;
    assign alu_flags = {bus.s, bus.z, bus.op_result[5], bus.h,
                        bus.op_result[3], bus.pv, bus.n, bus.c};
    assign unused_op_bits = ^{bus.op_result[7:6], bus.op_result[4], bus.op_result[2:0]};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_merge
            assign upd_value[gi] = bus.upd_mask[gi] ? alu_flags[gi] : active[gi];
        end
    endgenerate

    assign write_en = bus.load_valid | bus.upd_valid;

    // Load has absolute priority over the ALU capture.
    always_comb begin
        write_value = (bus.load_valid ? bus.load_data : upd_value) & keep_mask;
    end

    // Value that f will show after the coming edge; a swap exposes the untouched bank.
    always_comb begin
        f_next = active;
        if (bus.ex_af) begin
            f_next = inactive;
        end else if (write_en) begin
            f_next = write_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank0_reg     <= reset_value;
            bank1_reg     <= reset_value;
            bank_sel_reg  <= 1'b0;
            f_changed_reg <= 1'b0;
        end else begin
            if (write_en && !bank_sel_reg) begin
                bank0_reg <= write_value;
            end
            if (write_en && bank_sel_reg) begin
                bank1_reg <= write_value;
            end
            if (bus.ex_af) begin
                bank_sel_reg <= ~bank_sel_reg;
            end
            f_changed_reg <= |((f_next ^ active) & keep_mask);
        end
    end

    // cc_sel[2:1] picks the flag, cc_sel[0] picks the polarity (odd = flag set).
    always_comb begin
        cc_bit = 1'b0;
        case (bus.cc_sel[2:1])
            2'd0:    cc_bit = active[6];
            2'd1:    cc_bit = active[0];
            2'd2:    cc_bit = active[2];
            default: cc_bit = active[7];
        endcase
    end

    assign bus.cc_true   = bus.cc_sel[0] ? cc_bit : ~cc_bit;
    assign bus.f         = active;
    assign bus.f_shadow  = inactive;
    assign bus.f_changed = f_changed_reg;
endmodule

// File: tb/tb_alu_flag_register.sv
// Directed, table-driven bench for alu_flag_register (works with or without ALU_FLAG_XY_EN).
module tb_alu_flag_register;
`ifdef ALU_FLAG_XY_EN
    localparam logic [7:0] XYM = 8'hFF;
    localparam logic [7:0] R   = 8'hFF;
`else
    localparam logic [7:0] XYM = 8'hD7;
    localparam logic [7:0] R   = 8'hD7;
`endif
    localparam logic XY = XYM[5];

    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic       uv;
        logic [7:0] um;
        logic [5:0] fl;   // {s,z,h,pv,n,c}
        logic [7:0] op;
        logic       ex;
        logic [7:0] exp_f;
        logic [7:0] exp_sh;
        logic       exp_chg;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[20];
    logic [7:0] cc_exp;

    alu_flag_if #(.alu_width(8)) bus ();

    alu_flag_register #(.alu_width(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.c = 0; bus.n = 0; bus.pv = 0; bus.h = 0; bus.s = 0; bus.z = 0;
        bus.op_result = 8'h00; bus.upd_valid = 0; bus.upd_mask = 8'h00;
        bus.load_valid = 0; bus.load_data = 8'h00; bus.ex_af = 0; bus.cc_sel = 3'd0;
    endtask

    initial begin
        //            lv  ld     uv  um     fl         op     ex  exp_f            exp_sh  chg
        vecs[0]  = '{1'b1, 8'h3C & 8'h00, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b0, 8'h00, R, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h41, 6'b110001, 8'h00, 1'b0, 8'h41,         R,     1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'h00, 6'b111111, 8'hFF, 1'b0, 8'h41,         R,     1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 6'b001110, 8'h28, 1'b0, 8'h3E & XYM,   R,     1'b1};
        vecs[4]  = '{1'b1, 8'h3C, 1'b1, 8'hFF, 6'b111111, 8'hFF, 1'b0, 8'h3C & XYM,   R,     1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h01, 6'b000001, 8'h00, 1'b0, 8'h3D & XYM,   R,     1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h80, 6'b100000, 8'h00, 1'b0, 8'hBD & XYM,   R,     1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h80, 6'b100000, 8'h00, 1'b0, 8'hBD & XYM,   R,     1'b0};
        vecs[8]  = '{1'b1, 8'h80, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b1, R,             8'h80, 1'b1};
        vecs[9]  = '{1'b1, 8'h01, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b0, 8'h01,         8'h80, 1'b1};
        vecs[10] = '{1'b1, 8'h55, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b1, 8'h80,         8'h55, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b1, 8'h55,         8'h80, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b1, 8'h80,         8'h55, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b0, 8'h80,         8'h55, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 8'h28, 6'b000000, 8'h28, 1'b0, 8'h80 | (8'h28 & XYM), 8'h55, XY};
        vecs[15] = '{1'b1, 8'h55, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b0, 8'h55,         8'h55, 1'b1};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b1, 8'h55,         8'h55, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b1, 8'h55,         8'h55, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 8'h01, 6'b000000, 8'h00, 1'b1, 8'h55,         8'h54, 1'b0};
        vecs[19] = '{1'b1, 8'h85, 1'b0, 8'h00, 6'b000000, 8'h00, 1'b0, 8'h85,         8'h54, 1'b1};
        cc_exp = 8'b1010_1001;  // bit i = expected cc_true for cc_sel = i on F = 85

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.cc_sel = 3'd1;
        #1;
        check8("reset_f", bus.f, R);
        check8("reset_shadow", bus.f_shadow, R);
        check8("reset_changed", {7'b0, bus.f_changed}, 8'h00);
        check8("reset_cc_z", {7'b0, bus.cc_true}, 8'h01);
        $display("reset: f=%02h shadow=%02h", bus.f, bus.f_shadow);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.load_valid = vecs[i].lv;
            bus.load_data  = vecs[i].ld;
            bus.upd_valid  = vecs[i].uv;
            bus.upd_mask   = vecs[i].um;
            {bus.s, bus.z, bus.h, bus.pv, bus.n, bus.c} = vecs[i].fl;
            bus.op_result  = vecs[i].op;
            bus.ex_af      = vecs[i].ex;
            @(posedge clk);
            #1;
            check8($sformatf("vec%0d_f", i), bus.f, vecs[i].exp_f);
            check8($sformatf("vec%0d_shadow", i), bus.f_shadow, vecs[i].exp_sh);
            check8($sformatf("vec%0d_changed", i), {7'b0, bus.f_changed}, {7'b0, vecs[i].exp_chg});
            $display("vec %0d: f=%02h shadow=%02h changed=%0b", i, bus.f, bus.f_shadow, bus.f_changed);
        end

        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            bus.cc_sel = 3'(k);
            #1;
            check8($sformatf("cc_sel%0d", k), {7'b0, bus.cc_true}, {7'b0, cc_exp[k]});
            $display("cc_sel %0d: cc_true=%0b", k, bus.cc_true);
        end

        // Reset in mid-cycle with a write and a swap pending must act at once.
        @(posedge clk);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h00;
        bus.ex_af      = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check8("async_reset_f", bus.f, R);
        check8("async_reset_shadow", bus.f_shadow, R);
        check8("async_reset_changed", {7'b0, bus.f_changed}, 8'h00);
        @(posedge clk);
        #1;
        check8("held_reset_f", bus.f, R);
        check8("held_reset_shadow", bus.f_shadow, R);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        check8("post_reset_f", bus.f, R);
        check8("post_reset_changed", {7'b0, bus.f_changed}, 8'h00);
        $display("async reset: f=%02h shadow=%02h", bus.f, bus.f_shadow);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
